// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks the rows, debounces one press and its release,
// and pushes a single keycode per press into the key FIFO write port.
module keypad_scan_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic [3:0]            col_i,
    output logic [3:0]            row_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_wr_data_o,
    output logic                  key_down_o,
    output logic                  overflow_o,
    input  logic                  clr_overflow_i
);
    localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        PUSH,
        WAIT_RELEASE
    } state_t;

    state_t          state;
    logic [3:0]      col_meta;
    logic [3:0]      col_s;
    logic [1:0]      row;
    logic [1:0]      col;
    logic [DW_W-1:0] dwell;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      first_low;
    logic            col_hit;
    logic            lat_low;

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    // Columns are asynchronous to clk_i; two flops before anything looks at them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            // NOTE: non-blocking so col_s takes the old col_meta, giving a true two-stage chain.
            col_meta <= col_i;
            col_s    <= col_meta;
        end
    end

    always_comb begin
        // NOTE: default before the loop so every path assigns first_low and no latch is inferred.
        first_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) first_low = 2'(i);
        end
    end

    assign col_hit = (col_s != 4'hF);
    assign lat_low = ~col_s[col];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            row_o          <= 4'hF;
            row            <= 2'd0;
            col            <= 2'd0;
            dwell          <= '0;
            db_cnt         <= '0;
            fifo_wr_en_o   <= 1'b0;
            fifo_wr_data_o <= '0;
            key_down_o     <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            fifo_wr_en_o <= 1'b0;
            if (clr_overflow_i) overflow_o <= 1'b0;

            if (!enable_i) begin
                state      <= IDLE;
                row_o      <= 4'hF;
                row        <= 2'd0;
                dwell      <= '0;
                db_cnt     <= '0;
                key_down_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SCAN;
                        row   <= 2'd0;
                        dwell <= '0;
                        row_o <= row_drive(2'd0);
                    end
                    SCAN: begin
                        if (dwell == DWELL_LAST) begin
                            dwell <= '0;
                            if (col_hit) begin
                                col    <= first_low;
                                db_cnt <= '0;
                                state  <= DEBOUNCE;
                            end else begin
                                row   <= row + 2'd1;
                                row_o <= row_drive(row + 2'd1);
                            end
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (!lat_low) begin
                            state  <= SCAN;
                            dwell  <= '0;
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state      <= PUSH;
                            db_cnt     <= '0;
                            key_down_o <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    PUSH: begin
                        // Set placed after the clear above so a same-cycle drop wins.
                        if (fifo_full_i) begin
                            overflow_o <= 1'b1;
                        end else begin
                            fifo_wr_en_o   <= 1'b1;
                            fifo_wr_data_o <= DATA_WIDTH'({row, col});
                        end
                        state  <= WAIT_RELEASE;
                        db_cnt <= '0;
                    end
                    WAIT_RELEASE: begin
                        if (lat_low) begin
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state      <= SCAN;
                            row        <= row + 2'd1;
                            row_o      <= row_drive(row + 2'd1);
                            dwell      <= '0;
                            db_cnt     <= '0;
                            key_down_o <= 1'b0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        row_o <= 4'hF;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a behavioural keypad matrix drives col_i from row_o,
// expected keycodes are queued at press time and matched against observed FIFO writes.
module tb_keypad_scan_ctrl;
    localparam int DATA_WIDTH   = 8;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i;
    logic                  enable_i;
    logic [3:0]            col_i;
    logic [3:0]            row_o;
    logic                  fifo_full_i;
    logic                  fifo_wr_en_o;
    logic [DATA_WIDTH-1:0] fifo_wr_data_o;
    logic                  key_down_o;
    logic                  overflow_o;
    logic                  clr_overflow_i;

    logic [3:0] keys [4];
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [DATA_WIDTH-1:0] exp_q [$];
    logic [DATA_WIDTH-1:0] obs_mem [256];
    int                    obs_wr = 0;
    int                    obs_rd = 0;
    bit                    double_wr = 1'b0;
    logic                  prev_wr = 1'b0;

    keypad_scan_ctrl #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .enable_i      (enable_i),
        .col_i         (col_i),
        .row_o         (row_o),
        .fifo_full_i   (fifo_full_i),
        .fifo_wr_en_o  (fifo_wr_en_o),
        .fifo_wr_data_o(fifo_wr_data_o),
        .key_down_o    (key_down_o),
        .overflow_o    (overflow_o),
        .clr_overflow_i(clr_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_o[r]) col_i = col_i & ~keys[r];
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (fifo_wr_en_o === 1'b1) begin
                if (prev_wr === 1'b1) double_wr = 1'b1;
                obs_mem[obs_wr % 256] = fifo_wr_data_o;
                obs_wr++;
            end
            prev_wr = fifo_wr_en_o;
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_key(input logic val, input int budget, output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < budget) begin
            @(negedge clk_i);
            i++;
            if (key_down_o === val) ok = 1'b1;
        end
    endtask

    task automatic wait_row(input logic [3:0] val, input int budget, output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < budget) begin
            @(negedge clk_i);
            i++;
            if (row_o === val) ok = 1'b1;
        end
    endtask

    task automatic scoreboard_drain(input string name);
        logic [DATA_WIDTH-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                $display("FAIL %s: no write observed, expected data 0x%02h", name, e);
            end else begin
                if (obs_mem[obs_rd % 256] !== e)
                    $display("FAIL %s: wr_data got 0x%02h expected 0x%02h", name, obs_mem[obs_rd % 256], e);
                else
                    n_pass++;
                obs_rd++;
            end
        end
        n_checks++;
        if (obs_rd != obs_wr) begin
            $display("FAIL %s: extra writes got %0d expected 0", name, obs_wr - obs_rd);
            obs_rd = obs_wr;
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset;
        rst_n_i        = 1'b0;
        enable_i       = 1'b0;
        fifo_full_i    = 1'b0;
        clr_overflow_i = 1'b0;
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
        cycles(3);
        n_checks++; if (row_o !== 4'hF) $display("FAIL reset_row: got %h expected f", row_o); else n_pass++;
        n_checks++; if (fifo_wr_en_o !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en_o); else n_pass++;
        n_checks++; if (fifo_wr_data_o !== 8'h00) $display("FAIL reset_wr_data: got %h expected 00", fifo_wr_data_o); else n_pass++;
        n_checks++; if (key_down_o !== 1'b0) $display("FAIL reset_key_down: got %b expected 0", key_down_o); else n_pass++;
        n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow_o); else n_pass++;
        rst_n_i = 1'b1;
        cycles(3);
        n_checks++; if (row_o !== 4'hF) $display("FAIL idle_row: got %h expected f", row_o); else n_pass++;
    endtask

    task automatic test_scan;
        logic [3:0] seq [5];
        int         bad [5];
        bit         ok;
        seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        for (int g = 0; g < 5; g++) bad[g] = 0;
        enable_i = 1'b1;
        wait_row(4'hE, 10, ok);
        n_checks++; if (!ok) $display("FAIL scan_start: row_o got %h expected e", row_o); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cycles(1);
            if (row_o !== seq[i / 4]) bad[i / 4]++;
        end
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (bad[g] != 0) $display("FAIL scan_group%0d: %0d cycles off, expected row_o %h for 4 cycles", g, bad[g], seq[g]);
            else n_pass++;
        end
        scoreboard_drain("scan_no_write");
    endtask

    task automatic test_press;
        bit ok;
        keys[2][1] = 1'b1;
        exp_q.push_back(8'h09);
        cycles(100);
        n_checks++; if (key_down_o !== 1'b1) $display("FAIL press_held: key_down got %b expected 1", key_down_o); else n_pass++;
        keys[2][1] = 1'b0;
        cycles(1);
        n_checks++; if (key_down_o !== 1'b1) $display("FAIL press_release_debounce: key_down got %b expected 1", key_down_o); else n_pass++;
        wait_key(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL press_release: key_down got %b expected 0", key_down_o); else n_pass++;
        n_checks++; if (row_o !== 4'h7) $display("FAIL press_resume_row3: row_o got %h expected 7", row_o); else n_pass++;
        cycles(2);
        scoreboard_drain("press");
        n_checks++; if (fifo_wr_data_o !== 8'h09) $display("FAIL press_data_hold: got %h expected 09", fifo_wr_data_o); else n_pass++;
    endtask

    task automatic test_bounce;
        int kd_seen = 0;
        bit ok;
        for (int b = 0; b < 12; b++) begin
            keys[2][1] = 1'b1;
            for (int c = 0; c < 5; c++) begin
                cycles(1);
                if (key_down_o !== 1'b0) kd_seen++;
            end
            keys[2][1] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                cycles(1);
                if (key_down_o !== 1'b0) kd_seen++;
            end
        end
        n_checks++; if (kd_seen != 0) $display("FAIL bounce_key_down: %0d cycles high expected 0", kd_seen); else n_pass++;
        wait_row(4'h7, 40, ok);
        n_checks++; if (!ok) $display("FAIL bounce_scan_resume: row_o got %h expected 7 seen", row_o); else n_pass++;
        scoreboard_drain("bounce_no_write");
    endtask

    task automatic test_overflow;
        bit ok;
        fifo_full_i = 1'b1;
        keys[1][2] = 1'b1;
        wait_key(1'b1, 60, ok);
        n_checks++; if (!ok) $display("FAIL ovf_press: key_down got %b expected 1", key_down_o); else n_pass++;
        cycles(2);
        n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow_o); else n_pass++;
        keys[1][2] = 1'b0;
        wait_key(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL ovf_release: key_down got %b expected 0", key_down_o); else n_pass++;
        cycles(3);
        n_checks++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow_o); else n_pass++;
        clr_overflow_i = 1'b1;
        cycles(1);
        clr_overflow_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow_o); else n_pass++;
        fifo_full_i = 1'b0;
        scoreboard_drain("ovf_no_write");
    endtask

    task automatic test_multi_key;
        bit ok;
        keys[0][3] = 1'b1;
        keys[0][1] = 1'b1;
        exp_q.push_back(8'h01);
        wait_key(1'b1, 60, ok);
        n_checks++; if (!ok) $display("FAIL multi_press: key_down got %b expected 1", key_down_o); else n_pass++;
        cycles(30);
        keys[0][3] = 1'b0;
        keys[0][1] = 1'b0;
        wait_key(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL multi_release: key_down got %b expected 0", key_down_o); else n_pass++;
        cycles(2);
        scoreboard_drain("multi_key");
        n_checks++; if (fifo_wr_data_o !== 8'h01) $display("FAIL multi_data_hold: got %h expected 01", fifo_wr_data_o); else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        keys[0][0] = 1'b1;
        exp_q.push_back(8'h00);
        wait_key(1'b1, 60, ok);
        n_checks++; if (!ok) $display("FAIL b2b_press0: key_down got %b expected 1", key_down_o); else n_pass++;
        cycles(5);
        keys[0][0] = 1'b0;
        wait_key(1'b0, 40, ok);
        keys[3][3] = 1'b1;
        exp_q.push_back(8'h0F);
        wait_key(1'b1, 60, ok);
        n_checks++; if (!ok) $display("FAIL b2b_press15: key_down got %b expected 1", key_down_o); else n_pass++;
        cycles(5);
        keys[3][3] = 1'b0;
        wait_key(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL b2b_release: key_down got %b expected 0", key_down_o); else n_pass++;
        cycles(2);
        scoreboard_drain("back_to_back");
    endtask

    task automatic test_enable_abort;
        bit ok;
        keys[2][1] = 1'b1;
        wait_row(4'hB, 40, ok);
        n_checks++; if (!ok) $display("FAIL en_reach_row2: row_o got %h expected b", row_o); else n_pass++;
        cycles(8);
        enable_i = 1'b0;
        cycles(1);
        n_checks++; if (row_o !== 4'hF) $display("FAIL en_abort_row: got %h expected f", row_o); else n_pass++;
        n_checks++; if (key_down_o !== 1'b0) $display("FAIL en_abort_key_down: got %b expected 0", key_down_o); else n_pass++;
        cycles(30);
        scoreboard_drain("en_abort_no_write");
        enable_i = 1'b1;
        exp_q.push_back(8'h09);
        wait_key(1'b1, 60, ok);
        n_checks++; if (!ok) $display("FAIL en_repress: key_down got %b expected 1", key_down_o); else n_pass++;
        cycles(5);
        keys[2][1] = 1'b0;
        wait_key(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL en_release: key_down got %b expected 0", key_down_o); else n_pass++;
        cycles(2);
        scoreboard_drain("en_reenable");
    endtask

    task automatic test_reset_abort;
        bit ok;
        keys[2][1] = 1'b1;
        wait_row(4'hB, 40, ok);
        n_checks++; if (!ok) $display("FAIL rst_reach_row2: row_o got %h expected b", row_o); else n_pass++;
        cycles(8);
        rst_n_i = 1'b0;
        #1;
        n_checks++; if (row_o !== 4'hF) $display("FAIL rst_abort_row: got %h expected f", row_o); else n_pass++;
        n_checks++; if (fifo_wr_data_o !== 8'h00) $display("FAIL rst_abort_data: got %h expected 00", fifo_wr_data_o); else n_pass++;
        cycles(3);
        rst_n_i = 1'b1;
        exp_q.push_back(8'h09);
        wait_key(1'b1, 60, ok);
        n_checks++; if (!ok) $display("FAIL rst_repress: key_down got %b expected 1", key_down_o); else n_pass++;
        cycles(5);
        keys[2][1] = 1'b0;
        wait_key(1'b0, 40, ok);
        n_checks++; if (!ok) $display("FAIL rst_release: key_down got %b expected 0", key_down_o); else n_pass++;
        cycles(2);
        scoreboard_drain("rst_reenable");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_bounce();
        test_overflow();
        test_multi_key();
        test_back_to_back();
        test_enable_abort();
        test_reset_abort();
        n_checks++;
        if (double_wr) $display("FAIL wr_en_single_cycle: got back-to-back strobes expected none");
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
